// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared constants for the two-requester ALU arbiter.
// Holds the default datapath width, opcode encodings and FSM state encoding.
package alu_arb_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_core.sv
// alu_core: purely combinational AND/OR/XOR/ADD unit shared by both requesters.
// Optional macro ALU_ARB_FLAGS_EN adds the ADD carry-out port.
module alu_core
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_o
`ifdef ALU_ARB_FLAGS_EN
    ,
    output logic             carry_o
`endif
);

    logic [WIDTH-1:0] sum_r;

`ifdef ALU_ARB_FLAGS_EN
    logic [WIDTH:0] sum_w;
    assign sum_w   = {1'b0, a_i} + {1'b0, b_i};
    assign sum_r   = sum_w[WIDTH-1:0];
    // Carry only means something for ADD; logic ops report 0.
    assign carry_o = (op_i == OP_ADD) & sum_w[WIDTH];
`else
    // Modulo 2^WIDTH add, carry is simply not built.
    assign sum_r = a_i + b_i;
`endif

    // Opcode select.
    always_comb begin
        res_o = '0;
        case (op_i)
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            default: res_o = sum_r;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU between two requesters.
// IDLE grants and latches operands, EXEC registers the result, RESP pulses done.
// Optional macro ALU_ARB_FLAGS_EN adds registered zf/cf outputs.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] out,
    output logic             busy
`ifdef ALU_ARB_FLAGS_EN
    ,
    output logic             zf,
    output logic             cf
`endif
);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;      // last requester granted
    logic             win_q, win_d;      // requester owning the current op
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] alu_res;
    logic             pick;

    // Single request wins outright; a tie goes to whoever was not granted last.
    assign pick = (req0 & req1) ? ~ptr_q : req1;

`ifdef ALU_ARB_FLAGS_EN
    logic alu_carry;
    logic zf_q, cf_q;
    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_i(op_q), .a_i(a_q), .b_i(b_q), .res_o(alu_res), .carry_o(alu_carry)
    );
`else
    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_i(op_q), .a_i(a_q), .b_i(b_q), .res_o(alu_res)
    );
`endif

    // State, pointer and latched-operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b1;
            win_q   <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Next state: arbitrate and latch only in IDLE; EXEC/RESP ignore requests.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    win_d   = pick;
                    ptr_d   = pick;
                    op_d    = pick ? op1 : op0;
                    a_d     = pick ? A1  : A0;
                    b_d     = pick ? B1  : B0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Result register: loads at the end of EXEC, holds otherwise, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
`ifdef ALU_ARB_FLAGS_EN
            zf_q  <= 1'b0;
            cf_q  <= 1'b0;
`endif
        end else if (state_q == S_EXEC) begin
            out_q <= alu_res;
`ifdef ALU_ARB_FLAGS_EN
            zf_q  <= (alu_res == '0);
            cf_q  <= alu_carry;
`endif
        end
    end

    // Moore outputs: gnt marks the EXEC cycle, done marks the RESP cycle.
    always_comb begin
        gnt0  = (state_q == S_EXEC) & ~win_q;
        gnt1  = (state_q == S_EXEC) &  win_q;
        done0 = (state_q == S_RESP) & ~win_q;
        done1 = (state_q == S_RESP) &  win_q;
        busy  = (state_q != S_IDLE);
    end

    assign out = out_q;
`ifdef ALU_ARB_FLAGS_EN
    assign zf  = zf_q;
    assign cf  = cf_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table plus hand sequences; per-requester scoreboards
// are filled when a request is driven and drained by the done monitor.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int W = WIDTH_DEF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [1:0]   op0 = '0, op1 = '0;
    logic [W-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic         gnt0, gnt1, done0, done1, busy;
    logic [W-1:0] out;
`ifdef ALU_ARB_FLAGS_EN
    logic         zf, cf;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .out(out), .busy(busy)
`ifdef ALU_ARB_FLAGS_EN
        , .zf(zf), .cf(cf)
`endif
    );

    typedef struct {
        logic         who;
        logic [1:0]   op;
        logic [W-1:0] a, b, res;
        logic         ezf, ecf;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         ezf, ecf;
    } exp_t;

    exp_t         q0[$], q1[$];
    int           gnt_log[$];
    int           checks = 0, errors = 0;
    int           cyc = 0;
    int           last_gnt_cyc[2];
    logic         rst_at_edge = 1'b0;
    logic [W-1:0] hold = '0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    // Monitor: exclusivity, reset effect, done latency/value, out stability.
    always @(negedge clk) begin
        exp_t e;
        logic dn;
        checks++;
        if ((gnt0 && gnt1) || (done0 && done1)) begin
            errors++;
            $display("FAIL excl: gnt=%b%b done=%b%b required one-hot", gnt1, gnt0, done1, done0);
        end
        if (rst_at_edge) begin
            checks++;
            if (out !== '0 || busy !== 1'b0 || gnt0 || gnt1 || done0 || done1) begin
                errors++;
                $display("FAIL rst_out: out=%b busy=%b required out=0 busy=0 no gnt/done", out, busy);
            end
            hold = '0;
        end else begin
            if (gnt0) begin gnt_log.push_back(0); last_gnt_cyc[0] = cyc; end
            if (gnt1) begin gnt_log.push_back(1); last_gnt_cyc[1] = cyc; end
            for (int k = 0; k < 2; k++) begin
                dn = (k == 0) ? done0 : done1;
                if (dn) begin
                    checks++;
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        errors++;
                        $display("FAIL done%0d_unexpected: done with no pending op", k);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        if (out !== e.res) begin
                            errors++;
                            $display("FAIL done%0d_out: got %b required %b", k, out, e.res);
                        end
`ifdef ALU_ARB_FLAGS_EN
                        checks++;
                        if (zf !== e.ezf || cf !== e.ecf) begin
                            errors++;
                            $display("FAIL done%0d_flags: zf=%b cf=%b required zf=%b cf=%b", k, zf, cf, e.ezf, e.ecf);
                        end
`endif
                        checks++;
                        if (cyc != last_gnt_cyc[k] + 1) begin
                            errors++;
                            $display("FAIL done%0d_lat: done cycle %0d required %0d", k, cyc, last_gnt_cyc[k] + 1);
                        end
                    end
                    hold = out;
                end
            end
            if (!done0 && !done1) begin
                checks++;
                if (out !== hold) begin
                    errors++;
                    $display("FAIL out_hold: out=%b required held %b", out, hold);
                end
            end
        end
    end

    task automatic drive(input logic who, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (who) begin req1 = 1'b1; op1 = op; A1 = a; B1 = b; end
        else     begin req0 = 1'b1; op0 = op; A0 = a; B0 = b; end
    endtask

    task automatic push(input logic who, input logic [W-1:0] res, input logic ezf, input logic ecf);
        exp_t e;
        e.res = res; e.ezf = ezf; e.ecf = ecf;
        if (who) q1.push_back(e); else q0.push_back(e);
    endtask

    // which: 0 gnt0, 1 gnt1, 2 done0, 3 done1. Bounded wait; c = cycle seen or -1.
    task automatic wait_sig(input int which, output int c);
        logic s;
        c = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            case (which)
                0: s = gnt0;
                1: s = gnt1;
                2: s = done0;
                default: s = done1;
            endcase
            if (s) begin c = cyc; break; end
        end
        checks++;
        if (c < 0) begin
            errors++;
            $display("FAIL wait_timeout: signal %0d not seen within 20 cycles", which);
        end
    endtask

    task automatic do_op(input vec_t v);
        int cg, cd;
        drive(v.who, v.op, v.a, v.b);
        push(v.who, v.res, v.ezf, v.ecf);
        wait_sig(v.who ? 1 : 0, cg);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_exec: got %b required 1", busy);
        end
        if (v.who) req1 = 1'b0; else req0 = 1'b0;
        wait_sig(v.who ? 3 : 2, cd);
    endtask

    vec_t vecs[9];

    initial begin
        int cg, cg1, cd, ng, first;
        vecs[0] = '{1'b0, OP_OR,  4'b0101, 4'b1010, 4'b1111, 1'b0, 1'b0};
        vecs[1] = '{1'b1, OP_ADD, 4'b1100, 4'b1110, 4'b1010, 1'b0, 1'b1};
        vecs[2] = '{1'b0, OP_XOR, 4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b0};
        vecs[3] = '{1'b0, OP_AND, 4'b1111, 4'b0011, 4'b0011, 1'b0, 1'b0};
        vecs[4] = '{1'b1, OP_OR,  4'b1000, 4'b0001, 4'b1001, 1'b0, 1'b0};
        vecs[5] = '{1'b1, OP_ADD, 4'b0111, 4'b1001, 4'b0000, 1'b1, 1'b1};
        vecs[6] = '{1'b0, OP_XOR, 4'b1010, 4'b0110, 4'b1100, 1'b0, 1'b0};
        vecs[7] = '{1'b1, OP_AND, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0};
        vecs[8] = '{1'b0, OP_ADD, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk);
        checks++;
        if (gnt0 || gnt1 || done0 || done1 || busy || out !== '0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b%b done=%b%b busy=%b out=%b required all 0",
                     gnt1, gnt0, done1, done0, busy, out);
        end
        rst = 1'b0;

        // Table-driven single operations.
        for (int i = 0; i < 9; i++) do_op(vecs[i]);

        // Both requesting continuously from the first cycle after reset.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        gnt_log.delete();
        drive(1'b0, OP_ADD, 4'b0001, 4'b0010);
        drive(1'b1, OP_XOR, 4'b1111, 4'b0101);
        for (int i = 0; i < 2; i++) begin
            push(1'b0, 4'b0011, 1'b0, 1'b0);
            push(1'b1, 4'b1010, 1'b0, 1'b0);
        end
        ng = 0;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) ng++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (gnt_log.size() != 4 || gnt_log[0] != 0 || gnt_log[1] != 1 || gnt_log[2] != 0 || gnt_log[3] != 1) begin
            errors++;
            $display("FAIL rr_order: got %0d grants %p required 0,1,0,1", gnt_log.size(), gnt_log);
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL rr_pending: q0=%0d q1=%0d required 0,0", q0.size(), q1.size());
        end

        // Reset during EXEC discards the op.
        drive(1'b0, OP_ADD, 4'b0011, 4'b0001);
        wait_sig(0, cg);
        rst  = 1'b1;
        req0 = 1'b0;
        q0.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: out=%b busy=%b required 0 0", out, busy);
        end
        repeat (3) @(negedge clk);

        // Tie after reset: requester 0 first.
        drive(1'b0, OP_OR,  4'b0001, 4'b0110);
        drive(1'b1, OP_AND, 4'b1110, 4'b0111);
        push(1'b0, 4'b0111, 1'b0, 1'b0);
        push(1'b1, 4'b0110, 1'b0, 1'b0);
        first = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt0) begin first = 0; break; end
            if (gnt1) begin first = 1; break; end
        end
        checks++;
        if (first != 0) begin
            errors++;
            $display("FAIL tie_after_rst: first grant %0d required 0", first);
        end
        req0 = 1'b0;
        wait_sig(1, cg);
        req1 = 1'b0;
        wait_sig(3, cd);

        // req1 raised while requester 0 is in EXEC.
        drive(1'b0, OP_OR, 4'b1001, 4'b0100);
        push(1'b0, 4'b1101, 1'b0, 1'b0);
        wait_sig(0, cg);
        req0 = 1'b0;
        drive(1'b1, OP_AND, 4'b0110, 4'b0011);
        push(1'b1, 4'b0010, 1'b0, 1'b0);
        wait_sig(1, cg1);
        req1 = 1'b0;
        checks++;
        if (cg1 != cg + 3) begin
            errors++;
            $display("FAIL late_gnt1: gnt1 cycle %0d required %0d", cg1, cg + 3);
        end
        checks++;
        if (out !== 4'b1101) begin
            errors++;
            $display("FAIL late_hold: out=%b required 1101", out);
        end
        wait_sig(3, cd);
        repeat (2) @(negedge clk);

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL final_pending: q0=%0d q1=%0d required 0,0", q0.size(), q1.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
